sqrt_share_arbiter: RTL and testbench
=====================================

Name: sqrt_share_arbiter

Overview:
- Shares one combinational AHSQR k=14 square-root unit (16-bit radicand in, 8-bit root out) among NREQ Sobel gradient-magnitude requesters.
- Round-robin arbitration with valid/ready handshakes.
- One-entry registered result stage; every result is tagged with the requester ID.
- Sits between the per-lane Gx²+Gy² accumulators and the edge-threshold stage.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 16, radicand width; fixed to the sqrt unit input width
- QW, 8, root width; fixed to the sqrt unit output width
- IDW, $clog2(NREQ), requester ID width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester radicand valid
- req_data  in  NREQ*DW  packed radicands; lane i is bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant/accept; combinational
- rsp_valid  out  1  result valid
- rsp_data  out  QW  root of the accepted radicand
- rsp_id  out  IDW  index of the requester that produced rsp_data
- rsp_ready  in  1  downstream accepts the result
- accept_cnt  out  32  total accepted requests; wraps modulo 2^32

Behaviour:
- Reset values (synchronous, on any clk edge with rst=1):
  - rsp_valid=0, rsp_data=0, rsp_id=0, accept_cnt=0.
  - Round-robin pointer ptr=0.
  - Reset mid-transaction discards the held result; no req_ready in the reset cycle.
- Output stage is a 2-state FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when rsp_ready=1 and no new accept in that cycle.
  - FULL -> FULL on simultaneous drain and accept.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant:
  - When can_accept, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[i]=1 only for that i; all other bits are 0.
  - No valid requests, or can_accept=0: req_ready=0.
- Accept (req_valid[i] & req_ready[i]) on edge t:
  - rsp_data <= sqrt(lane i), rsp_id <= i, rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - accept_cnt += 1.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id hold stable and req_ready=0.
- Requesters must hold req_valid and req_data until accepted. The arbiter takes no action on deasserted requests.
- ptr changes only on accept. Idle cycles do not rotate priority.
- Fairness: any continuously valid requester is granted within NREQ accepts.
- Arithmetic: the sqrt result is used unmodified, with no rounding or correction.
  - Radicand 0 -> root 0.
  - Radicand 65535 must pass without overflow (QW=8 is sufficient).

Optional Feature:
- Macro: SQRT_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority: the lowest index wins; ptr is removed.
  - Starvation of high indices is allowed.
  - All other behaviour is unchanged.
- Undefined: round-robin as above (default).

Decomposition:
- Package sqrt_arb_pkg holds:
  - constants SQRT_DW=16 and SQRT_QW=8;
  - enum typedef out_state_t {EMPTY, FULL};
  - function rr_next(ptr, NREQ).
- One sub-module, the existing squareroot_AHSQR_k14 (ports R, final_op). Instantiate it once, fed by a mux on the granted lane.
- The arbiter logic (grant search, ptr, FSM) stays in the top. No further sub-modules.

Test Plan:
- Reset, then one request: rst=1 for 2 cycles -> all outputs 0. Then req_valid=4'b0001 with lane0=144 -> req_ready=4'b0001 in the same cycle. Next cycle: rsp_valid=1, rsp_id=0, rsp_data equal to a golden squareroot_AHSQR_k14 instance fed 144. accept_cnt=1.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,1. One result per cycle. accept_cnt=6 after 6 accepts.
- Backpressure: rsp_ready=0 with rsp_valid=1 for 5 cycles -> req_ready=4'b0000, rsp_data and rsp_id constant. rsp_ready=1 -> drain and new accept in the same cycle; rsp_valid stays 1.
- Boundaries: lane2=0 -> rsp_data=0, rsp_id=2. Lane3=65535 -> rsp_data equal to the golden output for 65535. ptr wraps 3->0 after lane 3 is granted.
- Reset mid-operation: rst=1 while FULL with rsp_ready=0 -> next cycle rsp_valid=0, ptr=0, accept_cnt=0. First post-reset grant goes to the lowest valid index.
- SQRT_ARB_FIXED_PRIO_EN defined: req_valid=4'b1010 held, rsp_ready=1 -> requester 1 is granted every cycle and requester 3 never.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_arb_pkg
//   Shared definitions for the square-root sharing arbiter.
//   - SQRT_DW / SQRT_QW : radicand and root widths of the shared sqrt unit
//   - out_state_t       : state of the one-entry registered result stage
//   - rr_next()         : round-robin pointer advance, wrapping modulo nreq
// ---------------------------------------------------------------------------
package sqrt_arb_pkg;

   localparam int SQRT_DW = 16;
   localparam int SQRT_QW = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Priority moves to the requester just after the one that was granted.
   function automatic int unsigned rr_next(input int unsigned ptr,
                                           input int unsigned nreq);
      return (ptr + 1 >= nreq) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/squareroot_AHSQR_k14.sv
// ---------------------------------------------------------------------------
// squareroot_AHSQR_k14
//   Combinational 16-bit square-root unit.
//   Ports:
//     R        in  16  radicand
//     final_op out  8  root, floor(sqrt(R)); 65535 -> 255, 0 -> 0
//   Digit-by-digit restoring recurrence, unrolled over the 8 root bits.
// ---------------------------------------------------------------------------
module squareroot_AHSQR_k14
   import sqrt_arb_pkg::*;
(
   input  logic [SQRT_DW-1:0] R,
   output logic [SQRT_QW-1:0] final_op
);

   logic [17:0]        rem;
   logic [17:0]        trial;
   logic [SQRT_QW-1:0] root;

   always_comb begin
      rem   = '0;
      trial = '0;
      root  = '0;
      for (int i = SQRT_QW - 1; i >= 0; i--) begin
         // Bring down the next radicand bit pair and try root digit 1.
         rem   = {rem[15:0], R[2*i +: 2]};
         trial = {8'd0, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[SQRT_QW-2:0], 1'b1};
         end else begin
            root = {root[SQRT_QW-2:0], 1'b0};
         end
      end
      final_op = root;
   end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// ---------------------------------------------------------------------------
// sqrt_share_arbiter
//   Shares one combinational square-root unit among NREQ requesters with
//   round-robin arbitration and a one-entry registered result stage.
//   Ports:
//     clk, rst    clock (rising edge), synchronous active-high reset
//     req_valid   per-requester radicand valid
//     req_data    packed radicands, lane i = req_data[i*DW +: DW]
//     req_ready   one-hot grant, combinational
//     rsp_valid   result valid
//     rsp_data    root of the accepted radicand
//     rsp_id      requester index of rsp_data
//     rsp_ready   downstream accepts the result
//     accept_cnt  total accepted requests, wraps modulo 2^32
//   Build option: define SQRT_ARB_FIXED_PRIO_EN for fixed priority (lowest
//   index wins, no rotating pointer).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. A requester holds valid and data stable until it sees ready; the
//   result stage holds rsp_valid/rsp_data/rsp_id stable until rsp_ready.
// ---------------------------------------------------------------------------
module sqrt_share_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = SQRT_DW,
   parameter int QW   = SQRT_QW,
   parameter int IDW  = $clog2(NREQ)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [QW-1:0]      rsp_data,
   output logic [IDW-1:0]     rsp_id,
   input  logic               rsp_ready,
   output logic [31:0]        accept_cnt
);

   out_state_t     state;
   out_state_t     state_next;
   logic           can_accept;
   logic           accept;
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [DW-1:0]  sqrt_in;
   logic [QW-1:0]  sqrt_out;
   int             cand;

`ifndef SQRT_ARB_FIXED_PRIO_EN
   logic [IDW-1:0] ptr;
`endif

   // Grant search: first valid lane starting at ptr (or at 0 with fixed
   // priority), wrapping around the requester set.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef SQRT_ARB_FIXED_PRIO_EN
         cand = k;
`else
         cand = int'(ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
`endif
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   state_next = accept ? FULL : EMPTY;
         FULL:    state_next = (rsp_ready && !accept) ? EMPTY : FULL;
         default: state_next = EMPTY;
      endcase
   end

   // Output logic. Reset suppresses any grant in the reset cycle.
   always_comb begin
      rsp_valid  = (state == FULL);
      can_accept = (state == EMPTY) || rsp_ready;
      accept     = can_accept && grant_found && !rst;
      req_ready  = accept ? (NREQ'(1) << grant_idx) : '0;
   end

   // Single shared sqrt unit fed by the granted lane.
   assign sqrt_in = req_data[int'(grant_idx)*DW +: DW];

   squareroot_AHSQR_k14 u_sqrt (
      .R        (sqrt_in),
      .final_op (sqrt_out)
   );

   // Result register and accept counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data   <= '0;
         rsp_id     <= '0;
         accept_cnt <= '0;
      end else if (accept) begin
         rsp_data   <= sqrt_out;
         rsp_id     <= grant_idx;
         accept_cnt <= accept_cnt + 32'd1;
      end
   end

`ifndef SQRT_ARB_FIXED_PRIO_EN
   // Priority rotates only on accept; idle cycles leave it in place.
   always_ff @(posedge clk) begin
      if (rst)         ptr <= '0;
      else if (accept) ptr <= IDW'(rr_next(32'(grant_idx), NREQ));
   end
`endif

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sqrt_share_arbiter
//   Self-checking bench for sqrt_share_arbiter (NREQ=4). A behavioural model
//   (exp_q holds the expected result in the output stage, m_ptr the
//   priority, m_cnt the accept count) predicts every cycle; a vector table
//   and hand-written sequences pin down the documented corner cases.
// ---------------------------------------------------------------------------
module tb_sqrt_share_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int QW   = 8;
   localparam int IDW  = 2;
   localparam int W    = IDW + QW;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic [QW-1:0]      rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               rsp_ready;
   logic [31:0]        accept_cnt;
   logic [DW-1:0]      gold_r;
   logic [QW-1:0]      gold_q;

   int          total = 0;
   int          bad   = 0;
   logic [W-1:0] exp_q[$];
   int          m_ptr = 0;
   logic [31:0] m_cnt = '0;
   logic [NREQ-1:0] obs_ready;
   int          last_g;

   typedef struct {
      logic [NREQ-1:0] v;
      logic            rr;
      logic [NREQ-1:0] ready;
      logic            valid;
      logic [IDW-1:0]  id;
      logic [QW-1:0]   data;
      logic [31:0]     cnt;
   } vec_t;

   vec_t tbl[$];

   sqrt_share_arbiter #(.NREQ(NREQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .rsp_ready  (rsp_ready),
      .accept_cnt (accept_cnt)
   );

   squareroot_AHSQR_k14 golden (
      .R        (gold_r),
      .final_op (gold_q)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int isqrt(input int x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic vec_t mk(input logic [NREQ-1:0] v, input logic rr,
                               input logic [NREQ-1:0] ready, input logic valid,
                               input int id, input int data, input int cnt);
      vec_t t;
      t.v = v; t.rr = rr; t.ready = ready; t.valid = valid;
      t.id = IDW'(id); t.data = QW'(data); t.cnt = 32'(cnt);
      return t;
   endfunction

   // Which lane the rules say gets granted this cycle, or -1.
   function automatic int model_grant(input logic [NREQ-1:0] v, input bit full,
                                      input logic rr, input logic r);
      int c;
      if (r || (full && !rr)) return -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef SQRT_ARB_FIXED_PRIO_EN
         c = k;
`else
         c = (m_ptr + k) % NREQ;
`endif
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // ---------------- driver + scoreboard ----------------
   // Called at posedge+1; drives one cycle, checks, returns at next posedge+1.
   task automatic do_cycle(input logic r, input logic [NREQ-1:0] v,
                           input logic rr);
      int              g;
      bit              full;
      logic [W-1:0]    e;
      logic [NREQ-1:0] exp_ready;
      logic [DW-1:0]   lane_val;
      rst = r; req_valid = v; rsp_ready = rr;
      #1;
      full      = (exp_q.size() != 0);
      g         = model_grant(v, full, rr, r);
      exp_ready = (g < 0) ? '0 : (NREQ'(1) << g);
      obs_ready = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(full));
      if (full) begin
         e = exp_q[0];
         check("rsp_id", 32'(rsp_id), 32'(e[W-1:QW]));
         check("rsp_data", 32'(rsp_data), 32'(e[QW-1:0]));
         if (!r && rr) void'(exp_q.pop_front());
      end
      lane_val = '0;
      if (g >= 0) lane_val = req_data[g*DW +: DW];
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         m_ptr = 0;
         m_cnt = '0;
      end else if (g >= 0) begin
         exp_q.push_back({IDW'(g), QW'(isqrt(int'(lane_val)))});
         m_ptr = (g + 1) % NREQ;
         m_cnt = m_cnt + 32'd1;
      end
      last_g = g;
      #1;
      check("accept_cnt", accept_cnt, m_cnt);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [NREQ-1:0] pend;
      logic            rr_r;
      logic            rst_r;
      logic [DW-1:0]   d;

`ifdef SQRT_ARB_FIXED_PRIO_EN
      tbl.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b1, 0, 12, 1));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(4'b1010, 1'b1, 4'b0010, 1'b1, 1, 20, 2 + i));
      tbl.push_back(mk(4'b1010, 1'b0, 4'b0000, 1'b1, 1, 20, 5));
      tbl.push_back(mk(4'b1000, 1'b1, 4'b1000, 1'b1, 3, 255, 6));
      tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 3, 255, 6));
`else
      tbl.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b1, 0, 12, 1));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0010, 1'b1, 1, 20, 2));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2, 0, 3));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b1000, 1'b1, 3, 255, 4));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0001, 1'b1, 0, 12, 5));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0010, 1'b1, 1, 20, 6));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1, 20, 6));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2, 0, 7));
      tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2, 0, 7));
      tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2, 0, 7));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 1'b1, 0, 12, 8));
      tbl.push_back(mk(4'b0101, 1'b1, 4'b0100, 1'b1, 2, 0, 9));
      tbl.push_back(mk(4'b1000, 1'b1, 4'b1000, 1'b1, 3, 255, 10));
      tbl.push_back(mk(4'b0110, 1'b1, 4'b0010, 1'b1, 1, 20, 11));
`endif

      // Reset: two cycles, first one unchecked (state unknown before it).
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      req_data = {16'd65535, 16'd0, 16'd400, 16'd144};
      gold_r = 16'd144;
      @(posedge clk); #1;
      do_cycle(1'b1, 4'b0000, 1'b0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_accept_cnt", accept_cnt, 32'd0);

      // Table-driven vectors.
      foreach (tbl[i]) begin
         do_cycle(1'b0, tbl[i].v, tbl[i].rr);
         check("tbl_ready", 32'(obs_ready), 32'(tbl[i].ready));
         check("tbl_valid", 32'(rsp_valid), 32'(tbl[i].valid));
         check("tbl_id", 32'(rsp_id), 32'(tbl[i].id));
         check("tbl_data", 32'(rsp_data), 32'(tbl[i].data));
         check("tbl_cnt", accept_cnt, tbl[i].cnt);
         // Root must match the standalone sqrt unit fed the same radicand.
         gold_r = req_data[int'(tbl[i].id)*DW +: DW];
         #1;
         check("tbl_golden", 32'(rsp_data), 32'(gold_q));
      end

      // Boundary radicands through the standalone unit.
      gold_r = 16'd65535; #1;
      check("golden_65535", 32'(gold_q), 32'd255);
      gold_r = 16'd0; #1;
      check("golden_0", 32'(gold_q), 32'd0);

      // Reset while FULL and stalled: result discarded, priority back to 0.
      do_cycle(1'b0, 4'b1111, 1'b0);
      do_cycle(1'b0, 4'b1111, 1'b0);
      check("pre_reset_full", 32'(rsp_valid), 32'd1);
      do_cycle(1'b1, 4'b1111, 1'b0);
      check("mid_reset_ready", 32'(obs_ready), 32'd0);
      check("mid_reset_valid", 32'(rsp_valid), 32'd0);
      check("mid_reset_cnt", accept_cnt, 32'd0);
      check("mid_reset_data", 32'(rsp_data), 32'd0);
      do_cycle(1'b0, 4'b1100, 1'b1);
      check("post_reset_grant", 32'(obs_ready), 32'b0100);
      check("post_reset_id", 32'(rsp_id), 32'd2);
      check("post_reset_data", 32'(rsp_data), 32'd0);

      // Randomized traffic against the model. Requesters hold until granted.
      pend = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               case ($urandom_range(0, 7))
                  0:       d = 16'd0;
                  1:       d = 16'd65535;
                  default: d = DW'($urandom_range(0, 65535));
               endcase
               req_data[i*DW +: DW] = d;
            end
         end
         rst_r = ($urandom_range(0, 60) == 0);
         rr_r  = ($urandom_range(0, 3) != 0);
         do_cycle(rst_r, pend, rr_r);
         if (last_g >= 0) pend[last_g] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
